// File: rtl/data_req_issue_if.sv
// Data-memory SRAM-like request bus between the EX-side initiator and memory.
// master drives req/wr/size/addr/wstrb/wdata; slave returns addr_ok/data_ok.
interface data_req_issue_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size,
        output data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size,
        input  data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/data_req_issue.sv
// EX-side data-memory request issue: payload formation, request hold,
// outstanding-transaction tag FIFO and flush cancellation of responses.
// Ports: clk/resetn; op_* handshake from EX; ex_flush; dbus (master);
// rsp_valid/rsp_store/rsp_ldb response tags towards MEM.
module data_req_issue #(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_rt,
    input  logic        ex_flush,
    data_req_issue_if.master dbus,
    output logic        rsp_valid,
    output logic        rsp_store,
    output logic [1:0]  rsp_ldb
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_nx;

    logic [CW-1:0] outst_cnt;
    logic          take;
    logic          push;
    logic          pop;

    logic          p_store;
    logic [2:0]    p_type;
    logic [31:0]   p_addr;
    logic [31:0]   p_rt;
    logic          p_cancel;

    logic [MAX_OUTST-1:0]      f_store;
    logic [MAX_OUTST-1:0]      f_canc;
    logic [MAX_OUTST-1:0][1:0] f_ldb;
    logic [PW-1:0]             wp, rp;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    assign take = (state == IDLE) && op_valid && !ex_flush
               && (outst_cnt < CW'(MAX_OUTST));
    assign pop  = dbus.data_data_ok && (outst_cnt != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = REQ;
            REQ:     if (dbus.data_addr_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A flushed op keeps its request up until accepted; it only loses op_ready.
    always_comb begin
        dbus.data_req = (state == REQ);
        push          = (state == REQ) && dbus.data_addr_ok;
        op_ready      = push && !ex_flush && !p_cancel;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_store  <= 1'b0;
            p_type   <= '0;
            p_addr   <= '0;
            p_rt     <= '0;
            p_cancel <= 1'b0;
        end else if (take) begin
            p_store  <= op_store;
            p_type   <= op_type;
            p_addr   <= op_addr;
            p_rt     <= op_rt;
            p_cancel <= 1'b0;
        end else if (state == REQ && ex_flush) begin
            p_cancel <= 1'b1;
        end
    end

    logic [1:0]  lo;
    logic        is_h, is_b, is_wl, is_wr, is_w;
    logic [3:0]  strb;
    logic [31:0] wdat;
    logic [1:0]  size;
    logic [31:0] addr;

    assign lo    = p_addr[1:0];
    assign is_h  = (p_type == 3'b001);
    assign is_b  = (p_type == 3'b010);
    assign is_wl = (p_type == 3'b011);
    assign is_wr = (p_type == 3'b100);
    assign is_w  = !(is_h || is_b || is_wl || is_wr);

    // SWL writes the high bytes of rt into the low lanes up to addr;
    // SWR writes the low bytes of rt from addr upwards.
    always_comb begin
        size = 2'd2;
        addr = p_addr;
        strb = 4'b1111;
        wdat = p_rt;
        unique case (1'b1)
            is_h: begin
                size = 2'd1;
                strb = lo[1] ? 4'b1100 : 4'b0011;
                wdat = {2{p_rt[15:0]}};
            end
            is_b: begin
                size = 2'd0;
                strb = 4'b0001 << lo;
                wdat = {4{p_rt[7:0]}};
            end
            is_wl: begin
                addr = {p_addr[31:2], 2'b00};
                strb = 4'b1111 >> (~lo);
                wdat = p_rt >> {~lo, 3'b000};
            end
            is_wr: begin
                addr = {p_addr[31:2], 2'b00};
                strb = 4'b1111 << lo;
                wdat = p_rt << {lo, 3'b000};
            end
            is_w: ;
            default: ;
        endcase
    end

    always_comb begin
        dbus.data_wr    = 1'b0;
        dbus.data_size  = 2'd0;
        dbus.data_addr  = '0;
        dbus.data_wstrb = 4'b0000;
        dbus.data_wdata = '0;
        if (state == REQ) begin
            dbus.data_wr   = p_store;
            dbus.data_size = size;
            dbus.data_addr = addr;
            if (p_store) begin
                dbus.data_wstrb = strb;
                dbus.data_wdata = wdat;
            end
        end
    end

    // Flush cancels every queued entry; a same-cycle push is cancelled too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_store   <= '0;
            f_canc    <= '0;
            f_ldb     <= '0;
            wp        <= '0;
            rp        <= '0;
            outst_cnt <= '0;
        end else begin
            if (ex_flush) f_canc <= '1;
            if (push) begin
                f_store[wp] <= p_store;
                f_ldb[wp]   <= lo;
                f_canc[wp]  <= p_cancel || ex_flush;
                wp          <= inc(wp);
            end
            if (pop) rp <= inc(rp);
            unique case ({push, pop})
                2'b10:   outst_cnt <= outst_cnt + CW'(1);
                2'b01:   outst_cnt <= outst_cnt - CW'(1);
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

    assign rsp_valid = pop && !f_canc[rp];
    assign rsp_store = pop && f_store[rp];
    assign rsp_ldb   = pop ? f_ldb[rp] : 2'b00;

endmodule

// File: tb/tb_data_req_issue.sv
// Directed bench for data_req_issue: payload table plus hand sequences
// for stall, flush, simultaneous push/pop and mid-transaction reset.
module tb_data_req_issue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid, op_ready, op_store, ex_flush;
    logic [2:0]  op_type;
    logic [31:0] op_addr, op_rt;
    logic        rsp_valid, rsp_store;
    logic [1:0]  rsp_ldb;

    data_req_issue_if bus ();

    data_req_issue #(.MAX_OUTST(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_store (op_store),
        .op_type  (op_type),
        .op_addr  (op_addr),
        .op_rt    (op_rt),
        .ex_flush (ex_flush),
        .dbus     (bus),
        .rsp_valid(rsp_valid),
        .rsp_store(rsp_store),
        .rsp_ldb  (rsp_ldb)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic st, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] rt);
        op_valid = 1'b1;
        op_store = st;
        op_type  = ty;
        op_addr  = a;
        op_rt    = rt;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  ty;
        logic [31:0] a;
        logic [31:0] rt;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] da;
    } vec_t;

    vec_t vt[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 3'b010, 32'h1003, 32'h123456AB, 0, 4'b1000, 32'hABABABAB, 32'h1003};
        vt[1]  = '{1, 3'b011, 32'h2001, 32'hAABBCCDD, 2, 4'b0011, 32'h0000AABB, 32'h2000};
        vt[2]  = '{1, 3'b100, 32'h2002, 32'hAABBCCDD, 2, 4'b1100, 32'hCCDD0000, 32'h2000};
        vt[3]  = '{1, 3'b000, 32'h0040, 32'hDEADBEEF, 2, 4'b1111, 32'hDEADBEEF, 32'h0040};
        vt[4]  = '{1, 3'b001, 32'h3002, 32'h12345678, 1, 4'b1100, 32'h56785678, 32'h3002};
        vt[5]  = '{1, 3'b001, 32'h3000, 32'h12345678, 1, 4'b0011, 32'h56785678, 32'h3000};
        vt[6]  = '{1, 3'b010, 32'h1001, 32'h000000C3, 0, 4'b0010, 32'hC3C3C3C3, 32'h1001};
        vt[7]  = '{0, 3'b000, 32'h0104, 32'hFFFFFFFF, 2, 4'b0000, 32'h00000000, 32'h0104};
        vt[8]  = '{0, 3'b010, 32'h0107, 32'hFFFFFFFF, 0, 4'b0000, 32'h00000000, 32'h0107};
        vt[9]  = '{1, 3'b011, 32'h2003, 32'h11223344, 2, 4'b1111, 32'h11223344, 32'h2000};
        vt[10] = '{1, 3'b100, 32'h2003, 32'h11223344, 2, 4'b1000, 32'h44000000, 32'h2000};
        vt[11] = '{1, 3'b011, 32'h2000, 32'h11223344, 2, 4'b0001, 32'h00000011, 32'h2000};
        vt[12] = '{1, 3'b100, 32'h2001, 32'h11223344, 2, 4'b1110, 32'h22334400, 32'h2000};
        vt[13] = '{1, 3'b111, 32'h0055, 32'hCAFEF00D, 2, 4'b1111, 32'hCAFEF00D, 32'h0055};
        vt[14] = '{0, 3'b011, 32'h2002, 32'h55555555, 2, 4'b0000, 32'h00000000, 32'h2000};

        resetn = 1'b0;
        op_valid = 0; op_store = 0; op_type = 0; op_addr = 0; op_rt = 0;
        ex_flush = 0;
        bus.data_addr_ok = 0;
        bus.data_data_ok = 0;
        #12;
        chk("rst data_req", 32'(bus.data_req), 0);
        chk("rst op_ready", 32'(op_ready), 0);
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst wstrb", 32'(bus.data_wstrb), 0);
        chk("rst outst", 32'(dut.outst_cnt), 0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // payload table: accept in first REQ cycle, response one cycle later
        for (int i = 0; i < 15; i++) begin
            set_op(vt[i].st, vt[i].ty, vt[i].a, vt[i].rt);
            step();
            bus.data_addr_ok = 1;
            @(negedge clk);
            chk($sformatf("v%0d req", i), 32'(bus.data_req), 1);
            chk($sformatf("v%0d wr", i), 32'(bus.data_wr), 32'(vt[i].st));
            chk($sformatf("v%0d size", i), 32'(bus.data_size), 32'(vt[i].size));
            chk($sformatf("v%0d addr", i), bus.data_addr, vt[i].da);
            chk($sformatf("v%0d wstrb", i), 32'(bus.data_wstrb), 32'(vt[i].strb));
            chk($sformatf("v%0d wdata", i), bus.data_wdata, vt[i].wd);
            chk($sformatf("v%0d op_ready", i), 32'(op_ready), 1);
            step();
            op_valid = 0;
            bus.data_addr_ok = 0;
            bus.data_data_ok = 1;
            @(negedge clk);
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("v%0d rsp_store", i), 32'(rsp_store), 32'(vt[i].st));
            chk($sformatf("v%0d rsp_ldb", i), 32'(rsp_ldb), 32'(vt[i].a[1:0]));
            step();
            bus.data_data_ok = 0;
        end

        // back-to-back loads, delayed accept, third op stalls at limit
        set_op(0, 3'b010, 32'h101, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall req", 32'(bus.data_req), 1);
            chk("stall addr", bus.data_addr, 32'h101);
            chk("stall op_ready", 32'(op_ready), 0);
            step();
        end
        bus.data_addr_ok = 1;
        @(negedge clk);
        chk("b2b op_ready0", 32'(op_ready), 1);
        step();
        bus.data_addr_ok = 0;
        set_op(0, 3'b010, 32'h102, 0);
        step();
        bus.data_addr_ok = 1;
        @(negedge clk);
        chk("b2b addr1", bus.data_addr, 32'h102);
        chk("b2b op_ready1", 32'(op_ready), 1);
        step();
        bus.data_addr_ok = 0;
        set_op(0, 3'b010, 32'h103, 0);
        chk("b2b outst2", 32'(dut.outst_cnt), 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("limit stall", 32'(bus.data_req), 0);
            step();
        end
        bus.data_data_ok = 1;
        @(negedge clk);
        chk("b2b rsp0 valid", 32'(rsp_valid), 1);
        chk("b2b rsp0 ldb", 32'(rsp_ldb), 1);
        step();
        bus.data_data_ok = 0;
        @(negedge clk);
        chk("b2b capture cycle", 32'(bus.data_req), 0);
        step();
        bus.data_addr_ok = 1;
        @(negedge clk);
        chk("b2b op2 req", 32'(bus.data_req), 1);
        chk("b2b op2 addr", bus.data_addr, 32'h103);
        chk("b2b op2 ready", 32'(op_ready), 1);
        step();
        op_valid = 0;
        bus.data_addr_ok = 0;
        bus.data_data_ok = 1;
        @(negedge clk);
        chk("b2b rsp1 ldb", 32'(rsp_ldb), 2);
        step();
        @(negedge clk);
        chk("b2b rsp2 valid", 32'(rsp_valid), 1);
        chk("b2b rsp2 ldb", 32'(rsp_ldb), 3);
        step();
        bus.data_data_ok = 0;
        chk("b2b drained", 32'(dut.outst_cnt), 0);

        // flush while in REQ: request held, op_ready suppressed, response dropped
        set_op(0, 3'b001, 32'h3002, 0);
        step();
        ex_flush = 1;
        op_valid = 0;
        @(negedge clk);
        chk("flush req held", 32'(bus.data_req), 1);
        chk("flush op_ready", 32'(op_ready), 0);
        step();
        ex_flush = 0;
        bus.data_addr_ok = 1;
        @(negedge clk);
        chk("flush req still", 32'(bus.data_req), 1);
        chk("flush addr", bus.data_addr, 32'h3002);
        chk("flush late ready", 32'(op_ready), 0);
        step();
        bus.data_addr_ok = 0;
        set_op(1, 3'b000, 32'h44, 32'h1);
        step();
        bus.data_addr_ok = 1;
        @(negedge clk);
        chk("post-flush ready", 32'(op_ready), 1);
        step();
        op_valid = 0;
        bus.data_addr_ok = 0;
        bus.data_data_ok = 1;
        @(negedge clk);
        chk("flushed rsp dropped", 32'(rsp_valid), 0);
        step();
        @(negedge clk);
        chk("next rsp valid", 32'(rsp_valid), 1);
        chk("next rsp store", 32'(rsp_store), 1);
        step();
        bus.data_data_ok = 0;

        // flush in IDLE: no capture, queued entry cancelled
        set_op(0, 3'b010, 32'h1, 0);
        step();
        bus.data_addr_ok = 1;
        step();
        bus.data_addr_ok = 0;
        ex_flush = 1;
        set_op(0, 3'b010, 32'h2, 0);
        step();
        ex_flush = 0;
        op_valid = 0;
        @(negedge clk);
        chk("idle flush no capture", 32'(bus.data_req), 0);
        bus.data_data_ok = 1;
        @(negedge clk);
        chk("queued cancelled", 32'(rsp_valid), 0);
        step();
        bus.data_data_ok = 0;

        // simultaneous push and pop
        set_op(0, 3'b010, 32'h201, 0);
        step();
        bus.data_addr_ok = 1;
        step();
        bus.data_addr_ok = 0;
        set_op(1, 3'b010, 32'h202, 32'h7);
        step();
        bus.data_addr_ok = 1;
        bus.data_data_ok = 1;
        @(negedge clk);
        chk("sim op_ready", 32'(op_ready), 1);
        chk("sim rsp store", 32'(rsp_store), 0);
        chk("sim rsp ldb", 32'(rsp_ldb), 1);
        step();
        op_valid = 0;
        bus.data_addr_ok = 0;
        chk("sim outst", 32'(dut.outst_cnt), 1);
        @(negedge clk);
        chk("sim rsp2 store", 32'(rsp_store), 1);
        chk("sim rsp2 ldb", 32'(rsp_ldb), 2);
        step();
        bus.data_data_ok = 0;

        // reset while in REQ with one outstanding
        set_op(0, 3'b000, 32'h300, 0);
        step();
        bus.data_addr_ok = 1;
        step();
        bus.data_addr_ok = 0;
        set_op(0, 3'b000, 32'h304, 0);
        step();
        #2;
        resetn = 0;
        #1;
        chk("rst mid req", 32'(bus.data_req), 0);
        chk("rst mid outst", 32'(dut.outst_cnt), 0);
        op_valid = 0;
        step();
        resetn = 1;
        bus.data_data_ok = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("no rsp after rst", 32'(rsp_valid), 0);
            step();
        end
        bus.data_data_ok = 0;
        chk("empty pop held", 32'(dut.outst_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
